// File: rtl/pwm_servo_pkg.sv
// Shared servo timing law (50 MHz clock, 544 us = 0 deg, 515 cycles/deg) plus
// the capture-side state, width and result types.
package pwm_servo_pkg;

    localparam int MIN_CYC       = 27200;
    localparam int DEG_CYC       = 515;
    localparam int MAX_ANGLE     = 180;
    localparam int GLITCH_CYC    = 1000;
    localparam int MAX_PULSE_CYC = 150000;
    localparam int TIMEOUT_CYC   = 2000000;

    typedef logic [17:0] width_t;
    typedef logic [7:0]  angle_t;
    typedef logic [15:0] sub_t;
    typedef logic [20:0] idle_t;

    typedef enum logic [2:0] {WAIT_LOW, IDLE, MIN, DEG, OVER} cap_state_t;

    typedef struct packed {
        angle_t angle;
        logic   valid;
        logic   err;
        logic   lost;
    } cap_out_t;

endpackage

// File: rtl/pwm_servo_capture_if.sv
// Decoded-result bus of the four-channel servo capture block.
interface pwm_servo_capture_if;
    import pwm_servo_pkg::*;

    angle_t     angle1;
    angle_t     angle2;
    angle_t     angle3;
    angle_t     angle4;
    logic [3:0] angle_valid;
    logic [3:0] pulse_err;
    logic [3:0] signal_lost;

    modport master (output angle1, angle2, angle3, angle4, angle_valid, pulse_err, signal_lost);
    modport slave  (input  angle1, angle2, angle3, angle4, angle_valid, pulse_err, signal_lost);
endinterface

// File: rtl/pwm_capture_channel.sv
// One servo capture lane: synchronizer, width/degree counter cascade, decode FSM.
// SERVO_CAPTURE_TIMEOUT_EN adds the per-lane idle counter driving signal_lost.
module pwm_capture_channel
    import pwm_servo_pkg::*;
#(
    parameter int MIN_CYC       = pwm_servo_pkg::MIN_CYC,
    parameter int DEG_CYC       = pwm_servo_pkg::DEG_CYC,
    parameter int MAX_ANGLE     = pwm_servo_pkg::MAX_ANGLE,
    parameter int GLITCH_CYC    = pwm_servo_pkg::GLITCH_CYC,
    parameter int MAX_PULSE_CYC = pwm_servo_pkg::MAX_PULSE_CYC
`ifdef SERVO_CAPTURE_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = pwm_servo_pkg::TIMEOUT_CYC
`endif
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     servo,
    output cap_out_t out
);

    // Synchronizer is deliberately not reset so a pin held high across rst
    // stays high at s and WAIT_LOW can reject the partial pulse.
    logic s_meta, s;
    always_ff @(posedge clk) begin
        s_meta <= servo;
        s      <= s_meta;
    end

    cap_state_t state;
    width_t     w;
    angle_t     d;
    sub_t       c;
    angle_t     angle_r;
    logic       valid_r, err_r, lost_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= WAIT_LOW;
            w       <= '0;
            d       <= '0;
            c       <= '0;
            angle_r <= '0;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            case (state)
                WAIT_LOW: if (!s) state <= IDLE;
                IDLE: if (s) begin
                    state <= MIN;
                    w     <= width_t'(1);
                    d     <= '0;
                    c     <= '0;
                end
                MIN, DEG: begin
                    if (s) begin
                        w <= w + 1'b1;
                        if (state == DEG) begin
                            if (c == sub_t'(DEG_CYC - 1)) begin
                                c <= '0;
                                if (d != angle_t'(MAX_ANGLE)) d <= d + 1'b1;
                            end else begin
                                c <= c + 1'b1;
                            end
                        end
                        if (w == width_t'(MAX_PULSE_CYC - 1)) begin
                            state <= OVER;
                        end else if (state == MIN && w == width_t'(MIN_CYC - 1)) begin
                            state <= DEG;
                            c     <= '0;
                        end
                    end else begin
                        state <= IDLE;
                        if (w >= width_t'(GLITCH_CYC)) begin
                            angle_r <= (state == MIN) ? '0 : d;
                            valid_r <= 1'b1;
                        end
                    end
                end
                OVER: if (!s) begin
                    state <= IDLE;
                    err_r <= 1'b1;
                end
                default: state <= WAIT_LOW;
            endcase
        end
    end

`ifdef SERVO_CAPTURE_TIMEOUT_EN
    idle_t idle_cnt;
    logic  s_q;
    always_ff @(posedge clk) begin
        s_q <= s;
        if (rst) begin
            idle_cnt <= '0;
            lost_r   <= 1'b1;
        end else begin
            if (s && !s_q)
                idle_cnt <= '0;
            else if (idle_cnt != idle_t'(TIMEOUT_CYC))
                idle_cnt <= idle_cnt + 1'b1;
            // Loss latches until a good pulse has been delivered.
            if (idle_cnt == idle_t'(TIMEOUT_CYC))
                lost_r <= 1'b1;
            else if (valid_r)
                lost_r <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) lost_r <= 1'b1;
        else     lost_r <= 1'b0;
    end
`endif

    assign out = '{angle: angle_r, valid: valid_r, err: err_r, lost: lost_r};

endmodule

// File: rtl/pwm_servo_capture.sv
// Four-channel servo pulse-width decoder; lanes map to numbered ports.
// Optional SERVO_CAPTURE_TIMEOUT_EN enables per-channel signal-loss detection.
module pwm_servo_capture
    import pwm_servo_pkg::*;
#(
    parameter int MIN_CYC       = pwm_servo_pkg::MIN_CYC,
    parameter int DEG_CYC       = pwm_servo_pkg::DEG_CYC,
    parameter int MAX_ANGLE     = pwm_servo_pkg::MAX_ANGLE,
    parameter int GLITCH_CYC    = pwm_servo_pkg::GLITCH_CYC,
    parameter int MAX_PULSE_CYC = pwm_servo_pkg::MAX_PULSE_CYC
`ifdef SERVO_CAPTURE_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = pwm_servo_pkg::TIMEOUT_CYC
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       servo1,
    input  logic                       servo2,
    input  logic                       servo3,
    input  logic                       servo4,
    pwm_servo_capture_if.master        cap
);

    localparam int NUM_CH = 4;

    logic [NUM_CH-1:0]     servo_v;
    cap_out_t [NUM_CH-1:0] ch;
    logic [NUM_CH-1:0]     valid_v, err_v, lost_v;

    assign servo_v = {servo4, servo3, servo2, servo1};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_capture_channel #(
            .MIN_CYC      (MIN_CYC),
            .DEG_CYC      (DEG_CYC),
            .MAX_ANGLE    (MAX_ANGLE),
            .GLITCH_CYC   (GLITCH_CYC),
            .MAX_PULSE_CYC(MAX_PULSE_CYC)
`ifdef SERVO_CAPTURE_TIMEOUT_EN
            , .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .servo(servo_v[g]),
            .out  (ch[g])
        );
    end

    always_comb begin
        valid_v = '0;
        err_v   = '0;
        lost_v  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            valid_v[i] = ch[i].valid;
            err_v[i]   = ch[i].err;
            lost_v[i]  = ch[i].lost;
        end
    end

    assign cap.angle1      = ch[0].angle;
    assign cap.angle2      = ch[1].angle;
    assign cap.angle3      = ch[2].angle;
    assign cap.angle4      = ch[3].angle;
    assign cap.angle_valid = valid_v;
    assign cap.pulse_err   = err_v;
    assign cap.signal_lost = lost_v;

endmodule

// File: tb/tb_pwm_servo_capture.sv
// Bench for pwm_servo_capture using a time-scaled timing law so every case
// fits a short run; expectations come from tables and an arithmetic model.
module tb_pwm_servo_capture;

    localparam int MIN_CYC       = 200;
    localparam int DEG_CYC       = 5;
    localparam int MAX_ANGLE     = 180;
    localparam int GLITCH_CYC    = 20;
    localparam int MAX_PULSE_CYC = 1500;
    localparam int TIMEOUT_CYC   = 3000;

    typedef struct packed {
        logic [3:0][11:0] w;
        logic [3:0][7:0]  ang;
        logic [3:0]       vld;
        logic [3:0]       err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] servo = 4'h0;
    int         checks = 0;
    int         errors = 0;
    int         cur_ang [4];
    logic [7:0] ang_o [4];

    pwm_servo_capture_if cif ();

    pwm_servo_capture #(
        .MIN_CYC      (MIN_CYC),
        .DEG_CYC      (DEG_CYC),
        .MAX_ANGLE    (MAX_ANGLE),
        .GLITCH_CYC   (GLITCH_CYC),
        .MAX_PULSE_CYC(MAX_PULSE_CYC)
`ifdef SERVO_CAPTURE_TIMEOUT_EN
        , .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .servo1(servo[0]),
        .servo2(servo[1]),
        .servo3(servo[2]),
        .servo4(servo[3]),
        .cap   (cif)
    );

    always #5 clk = ~clk;

    assign ang_o[0] = cif.angle1;
    assign ang_o[1] = cif.angle2;
    assign ang_o[2] = cif.angle3;
    assign ang_o[3] = cif.angle4;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Decode law from plain arithmetic: floor((w-MIN)/DEG), clamped.
    function automatic int model_angle(input int w);
        int a;
        if (w < MIN_CYC) return 0;
        a = (w - MIN_CYC) / DEG_CYC;
        return (a > MAX_ANGLE) ? MAX_ANGLE : a;
    endfunction

    function automatic vec_t mk(input int w0, w1, w2, w3, a0, a1, a2, a3,
                                input logic [3:0] vld, input logic [3:0] err);
        vec_t v;
        v.w[0] = 12'(w0); v.w[1] = 12'(w1); v.w[2] = 12'(w2); v.w[3] = 12'(w3);
        v.ang[0] = 8'(a0); v.ang[1] = 8'(a1); v.ang[2] = 8'(a2); v.ang[3] = 8'(a3);
        v.vld = vld;
        v.err = err;
        return v;
    endfunction

    // Drive pulses so all falls land on the same cycle, then watch 6 cycles.
    task automatic run_vec(input vec_t v, input string tag);
        int maxw = 0;
        for (int i = 0; i < 4; i++) if (int'(v.w[i]) > maxw) maxw = int'(v.w[i]);
        for (int t = 0; t < maxw; t++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++)
                servo[i] = (v.w[i] != 0) && (t >= maxw - int'(v.w[i]));
        end
        @(negedge clk);
        servo = 4'h0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("%s vld ch%0d k%0d", tag, i + 1, k),
                    int'(cif.angle_valid[i]), int'((k == 3) && v.vld[i]));
                chk($sformatf("%s err ch%0d k%0d", tag, i + 1, k),
                    int'(cif.pulse_err[i]), int'((k == 3) && v.err[i]));
                chk($sformatf("%s angle ch%0d k%0d", tag, i + 1, k),
                    int'(ang_o[i]), (k >= 3) ? int'(v.ang[i]) : cur_ang[i]);
            end
        end
`ifndef SERVO_CAPTURE_TIMEOUT_EN
        chk({tag, " lost"}, int'(cif.signal_lost), 0);
`endif
        for (int i = 0; i < 4; i++) cur_ang[i] = int'(v.ang[i]);
    endtask

    function automatic int rand_width();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return int'($urandom_range(1, GLITCH_CYC - 1));
            2:       return int'($urandom_range(GLITCH_CYC, MIN_CYC - 1));
            3:       return int'($urandom_range(MIN_CYC, MIN_CYC + MAX_ANGLE * DEG_CYC));
            4:       return int'($urandom_range(MIN_CYC + MAX_ANGLE * DEG_CYC + 1, MAX_PULSE_CYC - 1));
            default: return int'($urandom_range(MAX_PULSE_CYC, MAX_PULSE_CYC + 100));
        endcase
    endfunction

    initial begin
        vec_t tbl [8];
        vec_t rv;
        int   w;

        tbl[0] = mk(200,    0,    0,    0,   0,   0,   0,  0, 4'b0001, 4'b0000);
        tbl[1] = mk(  0,  650, 1100,    0,   0,  90, 180,  0, 4'b0110, 4'b0000);
        tbl[2] = mk(  0,  649,    0,    0,   0,  89, 180,  0, 4'b0010, 4'b0000);
        tbl[3] = mk(1300, 150,   10,    0, 180,   0, 180,  0, 4'b0011, 4'b0000);
        tbl[4] = mk(1500,   0,    0, 1600, 180,   0, 180,  0, 4'b0000, 4'b1001);
        tbl[5] = mk(  0,    0,    0,  650, 180,   0, 180, 90, 4'b1000, 4'b0000);
        tbl[6] = mk( 19, 1499,   20,  205, 180, 180,   0,  1, 4'b1110, 4'b0000);
        tbl[7] = mk(1099, 1104, 204,    0, 179, 180,   0,  1, 4'b0111, 4'b0000);

        for (int i = 0; i < 4; i++) cur_ang[i] = 0;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) chk($sformatf("reset angle ch%0d", i + 1), int'(ang_o[i]), 0);
        chk("reset valid", int'(cif.angle_valid), 0);
        chk("reset err", int'(cif.pulse_err), 0);
        chk("reset lost", int'(cif.signal_lost), 15);
        rst = 1'b0;
        repeat (3) @(negedge clk);
`ifdef SERVO_CAPTURE_TIMEOUT_EN
        chk("lost after reset", int'(cif.signal_lost), 15);
`else
        chk("lost after reset", int'(cif.signal_lost), 0);
`endif

        for (int n = 0; n < 8; n++) run_vec(tbl[n], $sformatf("tbl%0d", n));

        // Reset while servo4 is mid-pulse: nothing may decode from the tail.
        @(negedge clk);
        servo[3] = 1'b1;
        repeat (300) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) chk($sformatf("midrst angle ch%0d", i + 1), int'(ang_o[i]), 0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        servo[3] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("midrst no strobe k%0d", k), int'(cif.angle_valid), 0);
            chk($sformatf("midrst angle4 k%0d", k), int'(ang_o[3]), 0);
        end
        for (int i = 0; i < 4; i++) cur_ang[i] = 0;
        run_vec(mk(0, 0, 0, 650, 0, 0, 0, 90, 4'b1000, 4'b0000), "after_rst");

        for (int n = 0; n < 20; n++) begin
            rv = '0;
            for (int i = 0; i < 4; i++) begin
                w = rand_width();
                rv.w[i] = 12'(w);
                if (w == 0 || w < GLITCH_CYC) begin
                    rv.ang[i] = 8'(cur_ang[i]);
                end else if (w >= MAX_PULSE_CYC) begin
                    rv.ang[i] = 8'(cur_ang[i]);
                    rv.err[i] = 1'b1;
                end else begin
                    rv.ang[i] = 8'(model_angle(w));
                    rv.vld[i] = 1'b1;
                end
            end
            run_vec(rv, $sformatf("rnd%0d", n));
        end

`ifdef SERVO_CAPTURE_TIMEOUT_EN
        run_vec(mk(650, 650, 650, 650, 90, 90, 90, 90, 4'b1111, 4'b0000), "to_clear");
        chk("lost cleared", int'(cif.signal_lost), 0);
        repeat (TIMEOUT_CYC + 10) @(negedge clk);
        chk("lost after idle", int'(cif.signal_lost), 15);
        chk("angle1 held in loss", int'(ang_o[0]), 90);
        run_vec(mk(650, 0, 0, 0, 90, 90, 90, 90, 4'b0001, 4'b0000), "to_recover");
        chk("lost after recover", int'(cif.signal_lost), 14);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_servo_capture.md
Name: pwm_servo_capture

Overview:
- Four-channel servo PWM pulse-width decoder: the receive-side counterpart of the team's servo PWM generator.
- Measures the high time of each incoming servo pulse using the same timing law: 50 MHz clock, 544 µs (27200 cycles) = 0°, 515 cycles per degree, 20 ms frame.
- Converts each width back to an 8-bit angle, 0–180.
- Used for loopback verification of the generator and for reading external RC/servo command lines.

Parameters:
- MIN_CYC, 27200, pulse width in cycles representing 0°
- DEG_CYC, 515, cycles per degree
- MAX_ANGLE, 180, saturation angle
- GLITCH_CYC, 1000, pulses shorter than this are discarded
- MAX_PULSE_CYC, 150000, pulses longer than this are errors
- TIMEOUT_CYC, 2000000, cycles without a rising edge before signal loss is declared (2 frames)

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous active-high reset
- servo1..servo4  in  1 each  asynchronous servo pulse inputs
- angle1..angle4  out  8 each  last decoded angle per channel
- angle_valid  out  4  one-cycle strobe per channel on update; bit0 = channel 1
- pulse_err  out  4  one-cycle strobe per channel when an over-long pulse ends
- signal_lost  out  4  level per channel; high when no valid edge within TIMEOUT_CYC

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Input sync: each servoN passes through a 2-flop synchronizer. "s" denotes the synchronized level; all timing below refers to s.
- Reset values: angleN=0, angle_valid=0, pulse_err=0, signal_lost=4'hF; all counters 0; every channel FSM goes to WAIT_LOW.
- Per-channel FSM states: WAIT_LOW, IDLE, MIN, DEG, OVER.
  - WAIT_LOW: s=0 -> IDLE. Guarantees no partial measurement after reset or an error.
  - IDLE: s=1 -> MIN; width counter w=1, degree counter d=0, sub-counter c=0.
  - MIN: each s=1 cycle, w++. When w reaches MIN_CYC -> DEG with c=0.
  - DEG: each s=1 cycle, w++ and c++. When c reaches DEG_CYC-1: c=0, d++, with d saturating at MAX_ANGLE.
  - MIN/DEG: w reaching MAX_PULSE_CYC -> OVER.
  - OVER: s=0 -> IDLE and pulse_err strobe for 1 cycle. No angle update.
- Falling edge (s=0 in MIN or DEG):
  - w < GLITCH_CYC: -> IDLE, no strobe, angle held.
  - Otherwise: angleN <= (state==MIN) ? 0 : d, and angle_valid[N] strobes. Both appear in the same cycle, one clock after the first s=0 sample; total pin-fall to strobe is 3 clocks.
- Arithmetic: decoded angle = min(MAX_ANGLE, floor((w-MIN_CYC)/DEG_CYC)) for w >= MIN_CYC, else 0. No divider is used; the value comes from the counter cascade. w is 18 bits; d is 8 bits.
- Widths are counted in cycles with s=1 inclusive of the first high sample. A pulse of exactly MIN_CYC+k*DEG_CYC cycles decodes to k.
- Channels are fully independent. Simultaneous edges on all four channels may produce simultaneous strobes.
- rst mid-pulse: measurement is abandoned, angle resets to 0, and the channel returns to WAIT_LOW.
- Frame period is not checked; any rising edge starts a measurement.

Optional Feature:
- Macro: SERVO_CAPTURE_TIMEOUT_EN.
- Defined:
  - Each channel has a 21-bit idle counter, cleared on every rising edge of s and incremented otherwise, saturating at TIMEOUT_CYC.
  - signal_lost[N] is high while the counter equals TIMEOUT_CYC.
  - signal_lost[N] clears in the cycle after the next angle_valid[N] strobe.
  - angleN holds its value during loss.
- Not defined: no idle counter; signal_lost is tied to 4'h0 after reset.

Decomposition:
- Package pwm_servo_pkg holds:
  - timing constants MIN_CYC, DEG_CYC, MAX_ANGLE, GLITCH_CYC, MAX_PULSE_CYC, TIMEOUT_CYC, shared with the generator;
  - the typedef enum cap_state_t {WAIT_LOW, IDLE, MIN, DEG, OVER};
  - the width/angle typedefs.
- Sub-module pwm_capture_channel contains the synchronizer, FSM, counters and the timeout counter. The top level instantiates four copies and maps them to numbered ports.

Test Plan:
- Width 27200 cycles on servo1 -> angle1=0, angle_valid[0] strobes 3 clocks after the pin falls.
- Width 27200+90*515=73550 on servo2 and 119900 on servo3, falling on the same cycle -> angle2=90, angle3=180, strobes coincide; 73549 -> 89.
- Width 130000 -> 180 (saturated); width 20000 -> 0; width 500 -> no strobe, prior angle held.
- Width 160000 -> pulse_err strobe on the fall, no angle_valid, angle unchanged; the next 73550 pulse -> 90.
- rst asserted mid-pulse with servo4 held high -> angle4=0, no strobe until servo4 goes low and a new full pulse occurs.
- With SERVO_CAPTURE_TIMEOUT_EN: 2000000 idle cycles -> signal_lost[0]=1; the next 73550 pulse -> strobe, then signal_lost[0]=0. Without the macro: signal_lost stays 0.
